// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared widths, response record and FSM encoding for the multiplier
//   request scheduler (mult_req_sched) and its response FIFO (mult_rsp_fifo).
//   No ports; imported with `import mult_pkg::*;`.
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MUL_W    = 64;   // operand width
  localparam int HALF_W   = 32;   // multiplicand half fed to the array per pass
  localparam int PROD_W   = 128;  // full product width
  localparam int MAX_ID_W = 3;    // widest requester id (NUM_REQ up to 8)

  // One FIFO entry: requester id (zero-extended) and its product.
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [PROD_W-1:0]   prod;
  } mult_rsp_t;

  // S_IDLE doubles as the high-half pass whenever a grant is issued.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_LO   = 1'b1
  } mult_state_e;

endpackage

// File: rtl/mult_rsp_fifo.sv
// ---------------------------------------------------------------------------
// mult_rsp_fifo
//   Synchronous first-word-fall-through FIFO of mult_rsp_t entries.
//   The head entry is visible on o_rdata whenever o_valid is high.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   i_wr_en  in   push i_wdata (ignored when full without a same-cycle pop)
//   i_wdata  in   entry to push
//   i_rd_en  in   pop the head entry (ignored when empty)
//   o_valid  out  FIFO non-empty
//   o_rdata  out  head entry
//   o_count  out  number of stored entries (0..DEPTH)
// Parameters
//   DEPTH    entries, power of 2
// ---------------------------------------------------------------------------
module mult_rsp_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_en,
  input  mult_rsp_t              i_wdata,
  input  logic                   i_rd_en,
  output logic                   o_valid,
  output mult_rsp_t              o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  mult_rsp_t     r_mem [DEPTH];

  logic w_full;
  logic w_do_wr;
  logic w_do_rd;

  assign w_full  = (r_count == FULL_CNT);
  assign o_valid = (r_count != '0);
  assign w_do_rd = i_rd_en & o_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign w_do_wr = i_wr_en & (~w_full | w_do_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mult_req_sched.sv
// ---------------------------------------------------------------------------
// mult_req_sched
//   Round-robin scheduler sharing one two-pass 64x64 multiplier datapath
//   among NUM_REQ requesters. An accepted operation drives the high-half
//   pass in its accept cycle and the low-half pass in the next cycle, then
//   rides an in-flight pipe of DP_LAT stages that lines up with the
//   datapath latency; on pipe exit {id, dp_res} is written into a
//   first-word-fall-through response FIFO.
//
// Handshakes (valid/ready):
//   Request i transfers in a cycle where req_valid[i] & req_ready[i]; the
//   operands are sampled only then. req_ready is a one-hot combinational
//   grant, and req_valid may drop before a grant without effect.
//   A response transfers in a cycle where rsp_valid & rsp_ready;
//   rsp_id/rsp_prod hold while rsp_valid & ~rsp_ready.
//
// Ports
//   clk, rst                  clock (rising) / async active-low reset
//   req_valid/req_a/req_b     per-requester request, 64-bit slices
//   req_ready                 one-hot accept strobe
//   dp_a_half/dp_b/dp_first   datapath pass drive (dp_first=1: high pass)
//   dp_res                    datapath product, DP_LAT after the low pass
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_prod           head response
//   busy                      any operation in flight or FIFO non-empty
//   stat_ops/stat_stall       (MULT_REQ_SCHED_STATS_EN only) counters
//   dbg_state                 current FSM state
// Configuration
//   MULT_REQ_SCHED_STATS_EN   adds stat_ops (completed pushes) and
//                             stat_stall (IDLE cycles blocked on credit)
// ---------------------------------------------------------------------------
module mult_req_sched
  import mult_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int DP_LAT    = 3,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [HALF_W-1:0]        dp_a_half,
  output logic [MUL_W-1:0]         dp_b,
  output logic                     dp_first,
  input  logic [PROD_W-1:0]        dp_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PROD_W-1:0]        rsp_prod,
  output logic                     busy,
`ifdef MULT_REQ_SCHED_STATS_EN
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_stall,
`endif
  output mult_state_e              dbg_state
);

  mult_state_e r_state;
  mult_state_e w_state_nxt;

  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_gid;
  logic [HALF_W-1:0] r_a_lo;
  logic [MUL_W-1:0]  r_b;

  // In-flight pipe: stage k holds an op pushed k+1 cycles ago.
  logic [DP_LAT-1:0]           r_pipe_v;
  logic [DP_LAT-1:0][ID_W-1:0] r_pipe_id;

  logic [MUL_W-1:0] w_a_arr [NUM_REQ];
  logic [MUL_W-1:0] w_b_arr [NUM_REQ];

  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_pick_vld;
  logic [ID_W-1:0]      w_gid;
  logic [ID_W-1:0]      w_rr_nxt;
  logic                 w_grant;
  logic                 w_push_pipe;
  logic                 w_pipe_exit;
  int                   w_credit;
  logic                 w_credit_ok;

  logic [$clog2(RSP_DEPTH):0] w_fifo_count;
  mult_rsp_t                  w_wdata;
  mult_rsp_t                  w_rdata;
  logic                       w_unused_id;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*MUL_W +: MUL_W];
    assign w_b_arr[gi] = req_b[gi*MUL_W +: MUL_W];
  end

  // Rotating the doubled request vector by the pointer turns "first at or
  // after the pointer, wrapping" into a plain lowest-index search.
  always_comb begin
    w_rot      = {req_valid, req_valid} >> r_rr_ptr;
    w_pick_vld = 1'b0;
    w_gid      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_vld && w_rot[k]) begin
        w_pick_vld = 1'b1;
        w_gid      = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_rr_nxt = (int'(w_gid) == NUM_REQ - 1) ? '0 : w_gid + 1'b1;

  // Every op past its accept cycle owns a FIFO slot until popped, so the
  // FIFO can never be asked to take more than it holds.
  assign w_credit = RSP_DEPTH - int'(w_fifo_count) - $countones(r_pipe_v)
                    - ((r_state == S_LO) ? 1 : 0);
  assign w_credit_ok = (w_credit > 0);

  // rst gates the grant so req_ready stays low while reset is held.
  assign w_grant = rst & (r_state == S_IDLE) & w_pick_vld & w_credit_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    dp_first    = 1'b1;
    dp_a_half   = '0;
    dp_b        = '0;
    w_push_pipe = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ready[w_gid] = 1'b1;
          dp_a_half        = w_a_arr[w_gid][MUL_W-1:HALF_W];
          dp_b             = w_b_arr[w_gid];
          w_state_nxt      = S_LO;
        end
      end
      S_LO: begin
        dp_first    = 1'b0;
        dp_a_half   = r_a_lo;
        dp_b        = r_b;
        w_push_pipe = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr  <= '0;
      r_gid     <= '0;
      r_a_lo    <= '0;
      r_b       <= '0;
      r_pipe_v  <= '0;
      r_pipe_id <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_rr_nxt;
        r_gid    <= w_gid;
        r_a_lo   <= w_a_arr[w_gid][HALF_W-1:0];
        r_b      <= w_b_arr[w_gid];
      end
      r_pipe_v[0]  <= w_push_pipe;
      r_pipe_id[0] <= r_gid;
      for (int k = 1; k < DP_LAT; k++) begin
        r_pipe_v[k]  <= r_pipe_v[k-1];
        r_pipe_id[k] <= r_pipe_id[k-1];
      end
    end
  end

  // The last pipe stage is valid exactly in the cycle dp_res carries its
  // product, so the product is written straight into the FIFO.
  assign w_pipe_exit  = r_pipe_v[DP_LAT-1];
  assign w_wdata.id   = MAX_ID_W'(r_pipe_id[DP_LAT-1]);
  assign w_wdata.prod = dp_res;

  mult_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_wr_en (w_pipe_exit),
    .i_wdata (w_wdata),
    .i_rd_en (rsp_ready),
    .o_valid (rsp_valid),
    .o_rdata (w_rdata),
    .o_count (w_fifo_count)
  );

  assign rsp_id      = ID_W'(w_rdata.id);
  assign rsp_prod    = w_rdata.prod;
  assign w_unused_id = ^w_rdata.id;

  assign busy      = (r_state == S_LO) | (|r_pipe_v) | (w_fifo_count != '0);
  assign dbg_state = r_state;

`ifdef MULT_REQ_SCHED_STATS_EN
  logic [31:0] r_stat_ops;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_ops   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pipe_exit) r_stat_ops <= r_stat_ops + 32'd1;
      if ((r_state == S_IDLE) && (|req_valid) && !w_credit_ok)
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_ops   = r_stat_ops;
  assign stat_stall = r_stat_stall;
`endif

endmodule
